// File: rtl/asap_pkg.sv
`default_nettype none
// ============================================================================
// asap_pkg : shared constants and helpers for the ASAP-1 datapath blocks
// Revision : 1.0
// ============================================================================
package asap_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic longint unsigned default_modulus(input int width);
        return 64'd1 << width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_next.sv
`default_nettype none
// ============================================================================
// counter_next : next-count value, limit-hit flag and terminal count
// Revision : 1.0
// ============================================================================
module counter_next
    import asap_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = default_modulus(WIDTH),
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] next_o,
    output logic             hit_o,
    output logic             tc_o
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_at_top;
    logic           w_at_bot;
    logic           w_hit;

    assign w_inc = {1'b0, data_i} + (WIDTH+1)'(1);
    assign w_dec = {1'b0, data_i} - (WIDTH+1)'(1);

    // data+1 reaching MODULUS also covers out-of-range values loaded from the bus
    assign w_at_top = (w_inc >= MOD_EXT);
    // borrow out of the extended subtract means data was zero
    assign w_at_bot = w_dec[WIDTH];

    assign w_hit = (down_i == DIR_DOWN) ? w_at_bot : w_at_top;

    generate
        if (SATURATE == MODE_SAT) begin : g_sat
            always_comb begin
                if (w_hit) begin
                    next_o = data_i;
                end else if (down_i == DIR_DOWN) begin
                    next_o = w_dec[WIDTH-1:0];
                end else begin
                    next_o = w_inc[WIDTH-1:0];
                end
            end
        end else begin : g_wrap
            always_comb begin
                if (w_hit) begin
                    next_o = (down_i == DIR_DOWN) ? TOP : '0;
                end else if (down_i == DIR_DOWN) begin
                    next_o = w_dec[WIDTH-1:0];
                end else begin
                    next_o = w_inc[WIDTH-1:0];
                end
            end
        end
    endgenerate

    assign hit_o = w_hit;
    assign tc_o  = w_hit;

endmodule
`default_nettype wire

// File: rtl/register_counter_param.sv
`default_nettype none
// ============================================================================
// register_counter_param : bus-attached register / modulo up-down counter
// Revision : 1.0
// ============================================================================
module register_counter_param
    import asap_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter longint unsigned MODULUS     = default_modulus(WIDTH),
    parameter int              SATURATE    = MODE_WRAP,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ie,
    input  logic             oe,
    input  logic             clr,
    input  logic             step,
    input  logic             down,
    output logic [WIDTH-1:0] data,
    output logic             tc,
    output logic             cy,
    output logic             ovf,
    inout  wire  [WIDTH-1:0] bus
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "register_counter_param: WIDTH must be 2..32");
        end
        if (MODULUS < 2 || MODULUS > default_modulus(WIDTH)) begin : g_bad_modulus
            $fatal(1, "register_counter_param: MODULUS must be 2..2**WIDTH");
        end
        if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
            $fatal(1, "register_counter_param: SATURATE must be 0 or 1");
        end
        if (RESET_VALUE >= MODULUS) begin : g_bad_reset
            $fatal(1, "register_counter_param: RESET_VALUE must be below MODULUS");
        end
    endgenerate

    localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             cy_q;
    logic             cy_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] w_next;
    logic             w_hit;
    logic             w_tc;

    counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .data_i (data_q),
        .down_i (down),
        .next_o (w_next),
        .hit_o  (w_hit),
        .tc_o   (w_tc)
    );

    always_comb begin
        data_d = data_q;
        cy_d   = 1'b0;
        ovf_d  = ovf_q;
        if (clr) begin
            data_d = '0;
            ovf_d  = 1'b0;
        end else if (ie) begin
            // with oe also high the bus carries data_q, so this is a hold
            data_d = bus;
            ovf_d  = 1'b0;
        end else if (step) begin
            data_d = w_next;
            cy_d   = w_hit;
            ovf_d  = ovf_q | w_hit;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= RST_DATA;
            cy_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus  = oe ? data_q : {WIDTH{1'bz}};
    assign data = data_q;
    assign tc   = w_tc;
    assign cy   = cy_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: doc/register_counter_param.md
# register_counter_param

Parametrised successor to the 8-bit bus register/counter for the ASAP-1 datapath. It holds a WIDTH-bit value that can be loaded from the shared tristate bus, driven onto it, and counted up or down modulo MODULUS, with wrap or saturate behaviour. It also provides a terminal-count indication, a one-cycle carry/borrow pulse and a sticky overflow flag. Typical uses are the program counter, loop counters and general-purpose registers hanging off the bus.

## Interface
Parameters:
- WIDTH, 8: register and bus width in bits, 2 to 32.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1. Must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.
- RESET_VALUE, 0: value loaded by reset. Must be < MODULUS.

Ports:
- clk  in  1  system clock; all state changes on the falling edge.
- rst  in  1  reset, asynchronous, active-low.
- ie  in  1  load `data` from `bus` on the next falling edge.
- oe  in  1  drive `data` onto `bus`.
- clr  in  1  synchronous clear to 0.
- step  in  1  count enable.
- down  in  1  direction: 0 = up, 1 = down.
- data  out  WIDTH  current register value.
- tc  out  1  terminal count, combinational.
- cy  out  1  carry/borrow pulse, registered.
- ovf  out  1  sticky overflow, registered.
- bus  inout  WIDTH  shared tristate bus.

## Operation
Bus drive:
- `bus` = `data` when `oe` = 1, else high-Z.
- The drive is combinational and independent of `clk` and `rst`.

Update priority on each falling edge is `clr` > `ie` > `step`:
- **clr**: `data` ← 0; `cy` ← 0; `ovf` ← 0.
- **ie**: `data` ← `bus`.
  - A value ≥ MODULUS is stored unchanged; the next up-step from it takes the limit case.
  - `cy` ← 0; `ovf` ← 0.
- **step, up**:
  - If `data` ≥ MODULUS-1: with SATURATE=0, `data` ← 0; with SATURATE=1, `data` is held. In both cases `cy` ← 1 and `ovf` ← 1.
  - Otherwise `data` ← `data`+1 and `cy` ← 0.
- **step, down**:
  - If `data` = 0: with SATURATE=0, `data` ← MODULUS-1; with SATURATE=1, `data` is held. In both cases `cy` ← 1 and `ovf` ← 1.
  - Otherwise `data` ← `data`-1 and `cy` ← 0.
- **None asserted**: `data` and `ovf` hold; `cy` ← 0.

Terminal count:
- `tc` = (`down`=0 and `data` ≥ MODULUS-1) or (`down`=1 and `data`=0).
- `tc` does not depend on `step`.

Arithmetic:
- Unsigned, computed at WIDTH+1 bits internally.
- The stored result is always truncated to WIDTH bits.

## Timing
- Reset (`rst`=0): immediately, regardless of `clk`, `data` = RESET_VALUE, `cy` = 0, `ovf` = 0.
- Reset mid-count aborts the operation. The first falling edge after `rst` rises operates normally.
- Load latency: `data` takes the `bus` value at the falling edge where `ie`=1. The value is visible on `bus` from that edge if `oe`=1.
- Count latency: one falling edge per step.
- `cy` is high for exactly the one clk period following the limit edge.
- `ie`=1 and `oe`=1 together: the register reloads its own value (a hold). `step` is ignored.
- `ie`=1 while `bus` is undriven: `data` becomes X. This is the bus controller's responsibility; no protection is provided.
- `step` and `down` may change every cycle. Direction is sampled at the same edge as `step`.

## Structure
- Shared package `asap_pkg` holds:
  - The direction constants DIR_UP=0 and DIR_DOWN=1.
  - The mode constants MODE_WRAP=0 and MODE_SAT=1.
  - A function for the default modulus, 2**WIDTH.
- One combinational sub-module, `counter_next`, takes `data`, `down`, MODULUS and SATURATE. It produces the next count value, the limit-hit flag and `tc`.
- The top level holds:
  - The priority mux.
  - The flops, clocked on negedge `clk` with async `rst`.
  - The tristate driver.
- Parameter legality is checked at elaboration. An illegal combination is a fatal error.

## Test plan
- **Reset and bus load:** RESET_VALUE=5, pulse `rst` low mid-cycle → `data`=5, `cy`=0, `ovf`=0 with no clock edge. Then drive `bus`=0xA3 with `ie`=1 → `data`=0xA3 after one falling edge.
- **Up-wrap:** WIDTH=4, MODULUS=10, SATURATE=0, load 8, then `step`=1, `down`=0 for 3 edges → `data` = 9, 0, 1. `tc`=1 while `data`=9. `cy`=1 only in the period after 9→0. `ovf` stays 1 afterwards.
- **Down-saturate:** SATURATE=1, load 1, then `step`=1, `down`=1 for 3 edges → `data` = 0, 0, 0. `cy`=1 in the second and third periods. `ovf`=1.
- **Priority:** `clr`=1, `ie`=1 and `step`=1 on the same edge with `bus`=0x55 → `data`=0 and `ovf` cleared. Then `ie`=1 with `step`=1 → `data`=0x55, not 0x56.
- **Tristate:** `oe`=0 → `bus` is Z. `oe`=1 with `data`=0x3C → `bus`=0x3C within the same delta. `ie`=1 with `oe`=1 → `data` is unchanged.
- **Out-of-range load:** MODULUS=10, load 12, then step up → `data`=0, `cy`=1.
